sseg_word_scroller: RTL and testbench

Parametrised multi-digit seven-segment word display driver. It time-multiplexes NUM_DIGITS common-anode digits from an internal word ROM, with static, scrolling and blinking modes. Word and mode changes are applied only on frame boundaries, so the display never shows a torn frame. It sits between board-level control logic (FSMs selecting messages) and the seg/an pins.

---
 rtl/sseg_pkg.sv | 49 ++++
 rtl/sseg_char_decode.sv | 48 ++++
 rtl/sseg_word_scroller.sv | 165 ++++++++++++++++
 tb/tb_sseg_word_scroller.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared types for the seven-segment word scroller.
// Character codes, blank pattern and display modes.
package sseg_pkg;

  typedef logic [4:0] char_t;

  localparam char_t CH_0 = 5'd0;
  localparam char_t CH_1 = 5'd1;
  localparam char_t CH_2 = 5'd2;
  localparam char_t CH_3 = 5'd3;
  localparam char_t CH_4 = 5'd4;
  localparam char_t CH_5 = 5'd5;
  localparam char_t CH_6 = 5'd6;
  localparam char_t CH_7 = 5'd7;
  localparam char_t CH_8 = 5'd8;
  localparam char_t CH_9 = 5'd9;
  localparam char_t CH_A = 5'd10;
  localparam char_t CH_B = 5'd11;
  localparam char_t CH_C = 5'd12;
  localparam char_t CH_D = 5'd13;
  localparam char_t CH_E = 5'd14;
  localparam char_t CH_F = 5'd15;
  localparam char_t CH_G = 5'd16;
  localparam char_t CH_H = 5'd17;
  localparam char_t CH_I = 5'd18;
  localparam char_t CH_J = 5'd19;
  localparam char_t CH_L = 5'd20;
  localparam char_t CH_N = 5'd21;
  localparam char_t CH_O = 5'd22;
  localparam char_t CH_P = 5'd23;
  localparam char_t CH_R = 5'd24;
  localparam char_t CH_S = 5'd25;
  localparam char_t CH_T = 5'd26;
  localparam char_t CH_U = 5'd27;
  localparam char_t CH_V = 5'd28;
  localparam char_t CH_Y = 5'd29;
  localparam char_t CH_SPACE = 5'd30;
  localparam char_t CH_DASH = 5'd31;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    MODE_STATIC,
    MODE_SCROLL,
    MODE_BLINK,
    MODE_OFF
  } mode_t;

endpackage

// File: rtl/sseg_char_decode.sv
// Character code to active-low segment pattern.
// Bit order {a,b,c,d,e,f,g,dp}; dp is always off.
module sseg_char_decode
  import sseg_pkg::*;
(
  input  char_t      ch,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (ch)
      CH_0:     seg = 8'b00000011;
      CH_1:     seg = 8'b10011111;
      CH_2:     seg = 8'b00100101;
      CH_3:     seg = 8'b00001101;
      CH_4:     seg = 8'b10011001;
      CH_5:     seg = 8'b01001001;
      CH_6:     seg = 8'b01000001;
      CH_7:     seg = 8'b00011111;
      CH_8:     seg = 8'b00000001;
      CH_9:     seg = 8'b00001001;
      CH_A:     seg = 8'b00010001;
      CH_B:     seg = 8'b11000001;
      CH_C:     seg = 8'b01100011;
      CH_D:     seg = 8'b10000101;
      CH_E:     seg = 8'b01100001;
      CH_F:     seg = 8'b01110001;
      CH_G:     seg = 8'b01000011;
      CH_H:     seg = 8'b10010001;
      CH_I:     seg = 8'b11110011;
      CH_J:     seg = 8'b10000111;
      CH_L:     seg = 8'b11100011;
      CH_N:     seg = 8'b11010101;
      CH_O:     seg = 8'b11000101;
      CH_P:     seg = 8'b00110001;
      CH_R:     seg = 8'b11110101;
      CH_S:     seg = 8'b01001001;
      CH_T:     seg = 8'b11100001;
      CH_U:     seg = 8'b10000011;
      CH_V:     seg = 8'b11000111;
      CH_Y:     seg = 8'b10001001;
      CH_DASH:  seg = 8'b11111101;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_word_scroller.sv
// Multiplexed seven-segment word display with scroll/blink.
// Word and mode are only taken up on frame boundaries.
module sseg_word_scroller
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int WORD_LEN    = 8,
  parameter int NUM_WORDS   = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int STEP_DIV    = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(NUM_WORDS)-1:0] word_sel,
  input  logic [1:0]                   mode,
  output logic [7:0]                   seg,
  output logic [NUM_DIGITS-1:0]        an,
  output logic                         frame
);

  localparam int RW  = $clog2(REFRESH_DIV);
  localparam int DW  = $clog2(NUM_DIGITS);
  localparam int OW  = $clog2(WORD_LEN);
  localparam int SW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int WSW = $clog2(NUM_WORDS);

  localparam char_t ROM [4][4] = '{
    '{CH_P, CH_L, CH_A, CH_Y},
    '{CH_L, CH_I, CH_V, CH_E},
    '{CH_D, CH_E, CH_A, CH_D},
    '{CH_SPACE, CH_SPACE, CH_SPACE, CH_SPACE}
  };

  logic [RW-1:0]  rcnt;
  logic [DW-1:0]  dig;
  logic [OW-1:0]  offset;
  logic [SW-1:0]  step_cnt;
  logic           blank_ph;
  logic [WSW-1:0] cur_word;
  mode_t          cur_mode;

  logic [OW-1:0]  nxt_off;
  logic [SW-1:0]  nxt_step;
  logic           nxt_blank;
  logic [WSW-1:0] nxt_word;
  mode_t          nxt_mode;

  logic  rtc;
  logic  last_dig;
  logic  boundary;
  logic  changed;
  logic  step_wrap;
  mode_t mode_in;

  assign rtc       = (rcnt == RW'(REFRESH_DIV - 1));
  assign last_dig  = (dig == DW'(NUM_DIGITS - 1));
  assign boundary  = rtc & last_dig;
  assign mode_in   = mode_t'(mode);
  assign changed   = (word_sel != cur_word) || (mode_in != cur_mode);
  assign step_wrap = (step_cnt == SW'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
      dig  <= '0;
    end else if (rtc) begin
      rcnt <= '0;
      dig  <= last_dig ? '0 : dig + DW'(1);
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end

  always_comb begin
    nxt_word  = cur_word;
    nxt_mode  = cur_mode;
    nxt_off   = offset;
    nxt_step  = step_cnt;
    nxt_blank = blank_ph;
    if (boundary) begin
      nxt_word = word_sel;
      nxt_mode = mode_in;
      if (changed) begin
        nxt_off   = '0;
        nxt_step  = '0;
        nxt_blank = 1'b0;
      end else if (step_wrap) begin
        nxt_step = '0;
        case (cur_mode)
          MODE_SCROLL: begin
            if (offset == OW'(WORD_LEN - 1))
              nxt_off = '0;
            else
              nxt_off = offset + OW'(1);
          end
          MODE_BLINK: nxt_blank = ~blank_ph;
          default: ;
        endcase
      end else begin
        nxt_step = step_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_word <= '0;
      cur_mode <= MODE_STATIC;
      offset   <= '0;
      step_cnt <= '0;
      blank_ph <= 1'b0;
    end else begin
      cur_word <= nxt_word;
      cur_mode <= nxt_mode;
      offset   <= nxt_off;
      step_cnt <= nxt_step;
      blank_ph <= nxt_blank;
    end
  end

  // offset < WORD_LEN and dig < WORD_LEN, so one subtract wraps the sum
  logic [OW:0]   sum;
  logic [OW-1:0] cidx;
  logic [31:0]   w32;
  logic [31:0]   c32;
  char_t         ch;
  logic [7:0]    dec_seg;
  logic          blank_out;

  always_comb begin
    sum  = (OW+1)'(offset) + (OW+1)'(dig);
    cidx = OW'((sum >= (OW+1)'(WORD_LEN)) ? sum - (OW+1)'(WORD_LEN) : sum);
    w32  = 32'(cur_word);
    c32  = 32'(cidx);
    ch   = CH_SPACE;
    if (w32 < 32'd4 && c32 < 32'd4)
      ch = ROM[w32[1:0]][c32[1:0]];
  end

  sseg_char_decode u_dec (
    .ch  (ch),
    .seg (dec_seg)
  );

  assign blank_out = (cur_mode == MODE_OFF) ||
                     (cur_mode == MODE_BLINK && blank_ph);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg   <= SEG_BLANK;
      an    <= '1;
      frame <= 1'b0;
    end else begin
      frame <= boundary;
      if (blank_out) begin
        seg <= SEG_BLANK;
        an  <= '1;
      end else begin
        seg <= dec_seg;
        an  <= ~(NUM_DIGITS'(1) << dig);
      end
    end
  end

endmodule

// File: tb/tb_sseg_word_scroller.sv
// Scoreboard bench for sseg_word_scroller.
// Per-cycle expectations come from a frame-level display model.
module tb_sseg_word_scroller;

  localparam int ND = 4;
  localparam int WL = 8;
  localparam int NW = 4;
  localparam int RD = 4;
  localparam int SD = 2;
  localparam int FL = ND * RD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] word_sel;
  logic [1:0] mode;
  logic [7:0] seg;
  logic [3:0] an;
  logic       frame;

  always #5 clk = ~clk;

  sseg_word_scroller #(
    .NUM_DIGITS  (ND),
    .WORD_LEN    (WL),
    .NUM_WORDS   (NW),
    .REFRESH_DIV (RD),
    .STEP_DIV    (SD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .word_sel (word_sel),
    .mode     (mode),
    .seg      (seg),
    .an       (an),
    .frame    (frame)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       frame;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int n, m_word, m_mode, m_off, m_step, m_blank;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input byte c);
    case (c)
      "P": return 8'b00110001;
      "L": return 8'b11100011;
      "A": return 8'b00010001;
      "Y": return 8'b10001001;
      "I": return 8'b11110011;
      "V": return 8'b11000111;
      "E": return 8'b01100001;
      "D": return 8'b10000101;
      " ": return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic byte word_char(input int w, input int i);
    string s;
    case (w)
      0: s = "PLAY    ";
      1: s = "LIVE    ";
      2: s = "DEAD    ";
      default: s = "        ";
    endcase
    return s[i];
  endfunction

  task automatic model_reset();
    n = 0;
    m_word = 0;
    m_mode = 0;
    m_off = 0;
    m_step = 0;
    m_blank = 0;
  endtask

  task automatic tick();
    exp_t e;
    int d;
    bit dark;
    @(posedge clk);
    d = (n / RD) % ND;
    dark = (m_mode == 3) || (m_mode == 2 && m_blank == 1);
    e.frame = ((n % FL) == FL - 1);
    e.an = dark ? 4'hF : ~(4'b0001 << d);
    e.seg = dark ? 8'hFF : seg_of(word_char(m_word, (m_off + d) % WL));
    sbq.push_back(e);
    if (n % FL == FL - 1) begin
      if (int'(word_sel) != m_word || int'(mode) != m_mode) begin
        m_word = int'(word_sel);
        m_mode = int'(mode);
        m_off = 0;
        m_step = 0;
        m_blank = 0;
      end else if (m_step == SD - 1) begin
        m_step = 0;
        if (m_mode == 1) m_off = (m_off + 1) % WL;
        if (m_mode == 2) m_blank = 1 - m_blank;
      end else begin
        m_step++;
      end
    end
    n++;
    @(negedge clk);
    check("sb_depth", 32'(sbq.size()), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("seg", 32'(seg), 32'(e.seg));
      check("an", 32'(an), 32'(e.an));
      check("frame", 32'(frame), 32'(e.frame));
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_seg"}, 32'(seg), 32'hFF);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_frame"}, 32'(frame), 32'd0);
  endtask

  initial begin
    int b;
    rst_n = 1'b0;
    word_sel = 2'd0;
    mode = 2'd0;
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("rst");
    end
    model_reset();
    rst_n = 1'b1;

    run(3 * FL);

    mode = 2'd1;
    run(20 * FL);
    run(5);
    word_sel = 2'd1;
    run(1);
    word_sel = 2'd0;
    run(2 * FL);

    b = 0;
    while (!(m_mode == 1 && m_off == 3 && n % FL == 6) && b < 40 * FL) begin
      tick();
      b++;
    end
    check("wait_off3", 32'(b < 40 * FL), 32'd1);
    word_sel = 2'd2;
    run(3 * FL);

    run(5);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (2) begin
      @(negedge clk);
      check_reset_vals("midrst_hold");
    end
    sbq.delete();
    model_reset();
    word_sel = 2'd0;
    mode = 2'd2;
    rst_n = 1'b1;
    run(10 * FL);

    mode = 2'd3;
    run(3 * FL);
    mode = 2'd0;
    run(2 * FL);

    word_sel = 2'd1;
    run(2 * FL);

    for (int i = 0; i < 20 * FL; i++) begin
      if ($urandom_range(0, 15) == 0) word_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 23) == 0) mode = 2'($urandom_range(0, 3));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
